grn_attractor_ctrl: RTL and testbench

//  Sequencer on the controller side of the GRN node interface (reset_nos/start_s0/start_s1/init_state in; s0/s1 out).

---
 rtl/grn_attractor_ctrl_pkg.sv | 5 +
 rtl/grn_attractor_ctrl_if.sv | 16 +
 rtl/grn_attractor_ctrl.sv | 96 +++++++++
 tb/tb_grn_attractor_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/grn_attractor_ctrl_pkg.sv
// grn_attractor_ctrl_pkg: FSM state encoding and default counter width for the attractor sequencer
package grn_attractor_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, STEP, CMP, PSTEP, PCMP, DONE} state_t;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/grn_attractor_ctrl_if.sv
// grn_attractor_ctrl_if: result valid/ready bus (master = sequencer, slave = consumer)
//   res_valid/res_meet_steps/res_period/res_state/res_timeout: master -> slave
//   res_ready: slave -> master
interface grn_attractor_ctrl_if #(
  parameter int N_NODES = 8,
  parameter int CNT_W   = 16
);
  logic               res_valid;
  logic               res_ready;
  logic [CNT_W-1:0]   res_meet_steps;
  logic [CNT_W-1:0]   res_period;
  logic [N_NODES-1:0] res_state;
  logic               res_timeout;
  modport master (output res_valid, res_meet_steps, res_period, res_state, res_timeout, input res_ready);
  modport slave  (input res_valid, res_meet_steps, res_period, res_state, res_timeout, output res_ready);
endinterface

// File: rtl/grn_attractor_ctrl.sv
// grn_attractor_ctrl: Floyd attractor detection and period measurement sequencer for a GRN node array
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start, i_init_vec       run request and initial network state (sampled in IDLE)
//   o_busy                    run in progress
//   o_reset_nos, o_start_s0/1 registered one-cycle node control pulses
//   o_init_state              registered initial state to the nodes
//   i_s0_vec, i_s1_vec        node copy outputs
//   res                       result bus (master)
module grn_attractor_ctrl
  import grn_attractor_ctrl_pkg::*;
#(
  parameter int N_NODES   = 8,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MAX_STEPS = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [N_NODES-1:0]   i_init_vec,
  output logic                 o_busy,
  output logic                 o_reset_nos,
  output logic                 o_start_s0,
  output logic                 o_start_s1,
  output logic [N_NODES-1:0]   o_init_state,
  input  logic [N_NODES-1:0]   i_s0_vec,
  input  logic [N_NODES-1:0]   i_s1_vec,
  grn_attractor_ctrl_if.master res
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_STEPS);
  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_k, r_p;
  logic [N_NODES-1:0] r_init, r_res_state;
  logic               r_to, r_valid, r_reset_nos, r_s0, r_s1;
  logic               w_meet, w_loop, w_to;
  assign w_meet = (r_k >= CNT_W'(2)) && (i_s0_vec == i_s1_vec);
  assign w_loop = i_s1_vec == r_res_state;
  assign w_to   = w_next == DONE && ((r_state == CMP) || (r_state == PCMP && !w_loop));
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_start ? LOAD : IDLE;
      LOAD:    w_next = STEP;
      STEP:    w_next = CMP;
      CMP:     w_next = w_meet ? PSTEP : (r_k == MAX) ? DONE : STEP;
      PSTEP:   w_next = PCMP;
      PCMP:    w_next = (w_loop || r_p == MAX) ? DONE : PSTEP;
      DONE:    w_next = res.res_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // Pulses are registered from the next state so they are high exactly while in their state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_p         <= '0;
      r_init      <= '0;
      r_res_state <= '0;
      r_to        <= 1'b0;
      r_valid     <= 1'b0;
      r_reset_nos <= 1'b0;
      r_s0        <= 1'b0;
      r_s1        <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_reset_nos <= w_next == LOAD;
      r_s0        <= w_next == STEP;
      r_s1        <= w_next == STEP || w_next == PSTEP;
      r_valid     <= w_next == DONE;
      if (r_state == IDLE && i_start) r_init <= i_init_vec;
      if (r_state == LOAD) begin
        r_k         <= '0;
        r_p         <= '0;
        r_res_state <= '0;
        r_to        <= 1'b0;
      end
      if (r_state == STEP) r_k <= (r_k == MAX) ? r_k : r_k + CNT_W'(1);
      if (r_state == PSTEP) r_p <= (r_p == MAX) ? r_p : r_p + CNT_W'(1);
      if (r_state == CMP && w_meet) begin
        r_res_state <= i_s0_vec;
        r_p         <= '0;
      end
      if (w_to) r_to <= 1'b1;
    end
  end
  assign o_busy             = r_state != IDLE;
  assign o_reset_nos        = r_reset_nos;
  assign o_start_s0         = r_s0;
  assign o_start_s1         = r_s1;
  assign o_init_state       = r_init;
  assign res.res_valid      = r_valid;
  assign res.res_meet_steps = r_k;
  assign res.res_period     = r_p;
  assign res.res_state      = r_res_state;
  assign res.res_timeout    = r_to;
endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// tb_grn_attractor_ctrl: scoreboard bench with behavioural node copies driving two sequencer instances
module tb_grn_attractor_ctrl;
  typedef struct {
    logic [15:0] k;
    logic [15:0] p;
    logic [7:0]  st;
    logic        to;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic start_a = 0, start_b = 0;
  logic [7:0] init_a = 0, init_b = 0;
  logic busy_a, rn_a, s0p_a, s1p_a, busy_b, rn_b, s0p_b, s1p_b;
  logic [7:0] ist_a, ist_b;
  logic [7:0] n0_a, n1_a, n0_b, n1_b;
  logic pass_a, pass_b;
  int mode_a = 0, mode_b = 0;
  int checks = 0, failures = 0;
  int excl_viol = 0, nb_rn = 0, nb_s0 = 0, nb_s1 = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t e;
  logic [15:0] snap_k, snap_p;
  logic [7:0] snap_st;
  grn_attractor_ctrl_if #(.N_NODES(8), .CNT_W(16)) ifa ();
  grn_attractor_ctrl_if #(.N_NODES(8), .CNT_W(16)) ifb ();
  grn_attractor_ctrl #(.N_NODES(8), .CNT_W(16), .MAX_STEPS(1000)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_init_vec(init_a), .o_busy(busy_a),
    .o_reset_nos(rn_a), .o_start_s0(s0p_a), .o_start_s1(s1p_a), .o_init_state(ist_a),
    .i_s0_vec(n0_a), .i_s1_vec(n1_a), .res(ifa.master));
  grn_attractor_ctrl #(.N_NODES(8), .CNT_W(16), .MAX_STEPS(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_init_vec(init_b), .o_busy(busy_b),
    .o_reset_nos(rn_b), .o_start_s0(s0p_b), .o_start_s1(s1p_b), .o_init_state(ist_b),
    .i_s0_vec(n0_b), .i_s1_vec(n1_b), .res(ifb.master));
  always #5 clk = ~clk;
  function automatic logic [7:0] f(input int m, input logic [7:0] x);
    logic [2:0] c;
    c = x[2:0] + 3'd1;
    return (m == 0) ? x : (m == 1) ? {x[7:1], ~x[0]} : {5'd0, c};
  endfunction
  always @(posedge clk) begin
    if (rn_a) begin
      n0_a <= ist_a; n1_a <= ist_a; pass_a <= 1'b1;
    end else begin
      if (s1p_a) n1_a <= f(mode_a, n1_a);
      if (s0p_a) begin
        if (pass_a) n0_a <= f(mode_a, n0_a);
        pass_a <= ~pass_a;
      end
    end
    if (rn_b) begin
      n0_b <= ist_b; n1_b <= ist_b; pass_b <= 1'b1;
    end else begin
      if (s1p_b) n1_b <= f(mode_b, n1_b);
      if (s0p_b) begin
        if (pass_b) n0_b <= f(mode_b, n0_b);
        pass_b <= ~pass_b;
      end
    end
  end
  always @(negedge clk) begin
    if (rn_a && (s0p_a || s1p_a)) excl_viol++;
    if (rn_b && (s0p_b || s1p_b)) excl_viol++;
    nb_rn += int'(rn_b);
    nb_s0 += int'(s0p_b);
    nb_s1 += int'(s1p_b);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  // Independent Floyd model: s1 = f^k(x), s0 = f^ceil(k/2)(x), then walk s1 around the cycle.
  task automatic model(input int m, input logic [7:0] x, input int max, output exp_t r);
    logic [7:0] a, b;
    bit done;
    a = x; b = x; done = 0;
    r.k = 0; r.p = 0; r.st = 0; r.to = 0;
    for (int k = 1; k <= max && !done; k++) begin
      r.k = 16'(k);
      b = f(m, b);
      if (k % 2 == 1) a = f(m, a);
      if (k >= 2 && a == b) done = 1;
      else if (k == max) begin r.to = 1; return; end
    end
    r.st = a;
    for (int p = 1; p <= max; p++) begin
      r.p = 16'(p);
      b = f(m, b);
      if (b == a) return;
      if (p == max) r.to = 1;
    end
  endtask
  task automatic go_a(input int m, input logic [7:0] x);
    exp_t r;
    mode_a = m;
    model(m, x, 1000, r);
    qa.push_back(r);
    init_a = x; start_a = 1;
    @(negedge clk);
    start_a = 0;
  endtask
  task automatic wait_valid_a(input string tag);
    for (int c = 0; c < 5000 && !ifa.res_valid; c++) @(negedge clk);
    chk({tag, "_valid"}, 64'(ifa.res_valid), 64'd1);
  endtask
  task automatic cmp_a(input string tag);
    e = qa.pop_front();
    chk({tag, "_k"}, 64'(ifa.res_meet_steps), 64'(e.k));
    chk({tag, "_p"}, 64'(ifa.res_period), 64'(e.p));
    chk({tag, "_st"}, 64'(ifa.res_state), 64'(e.st));
    chk({tag, "_to"}, 64'(ifa.res_timeout), 64'(e.to));
  endtask
  initial begin
    exp_t r;
    ifa.res_ready = 1; ifb.res_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_outs", 64'({rn_a, s0p_a, s1p_a, ist_a, ifa.res_valid, ifa.res_meet_steps,
                         ifa.res_period, ifa.res_state, ifa.res_timeout}), 64'd0);
    rst_n = 1;
    @(negedge clk);
    go_a(0, 8'hA5);
    chk("run_busy", 64'(busy_a), 64'd1);
    wait_valid_a("ident"); cmp_a("ident");
    @(negedge clk);
    go_a(1, 8'h00);
    wait_valid_a("toggle"); cmp_a("toggle");
    @(negedge clk);
    go_a(2, 8'h05);
    wait_valid_a("count"); cmp_a("count");
    @(negedge clk);
    chk("idle_after", 64'(busy_a), 64'd0);
    mode_b = 2;
    model(2, 8'h05, 4, r);
    qb.push_back(r);
    init_b = 8'h05; start_b = 1;
    @(negedge clk);
    start_b = 0;
    for (int c = 0; c < 200 && !ifb.res_valid; c++) @(negedge clk);
    chk("tmo_valid", 64'(ifb.res_valid), 64'd1);
    e = qb.pop_front();
    chk("tmo_to", 64'(ifb.res_timeout), 64'(e.to));
    chk("tmo_k", 64'(ifb.res_meet_steps), 64'(e.k));
    chk("tmo_p", 64'(ifb.res_period), 64'(e.p));
    chk("tmo_s0_pulses", 64'(nb_s0), 64'd4);
    chk("tmo_s1_pulses", 64'(nb_s1), 64'd4);
    chk("tmo_load", 64'(nb_rn), 64'd1);
    ifa.res_ready = 0;
    @(negedge clk);
    go_a(1, 8'h00);
    wait_valid_a("hold");
    snap_k = ifa.res_meet_steps; snap_p = ifa.res_period; snap_st = ifa.res_state;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin init_a = 8'hFF; start_a = 1; end
      if (i == 4) start_a = 0;
      @(negedge clk);
      chk("hold_valid", 64'(ifa.res_valid), 64'd1);
      chk("hold_busy", 64'(busy_a), 64'd1);
      chk("hold_fields", 64'({ifa.res_meet_steps, ifa.res_period, ifa.res_state}),
          64'({snap_k, snap_p, snap_st}));
    end
    chk("hold_init_kept", 64'(ist_a), 64'h00);
    cmp_a("hold");
    ifa.res_ready = 1; start_a = 1; init_a = 8'h11;
    @(negedge clk);
    chk("handoff_valid", 64'(ifa.res_valid), 64'd0);
    chk("handoff_busy", 64'(busy_a), 64'd0);
    start_a = 0;
    @(negedge clk);
    chk("handoff_no_start", 64'(busy_a), 64'd0);
    go_a(2, 8'h05);
    begin
      int c;
      for (c = 0; c < 500 && !(s1p_a && !s0p_a); c++) @(negedge clk);
      chk("reach_pstep", 64'(s1p_a && !s0p_a), 64'd1);
    end
    #2 rst_n = 0;
    #1;
    chk("async_rst", 64'({busy_a, rn_a, s0p_a, s1p_a, ist_a, ifa.res_valid, ifa.res_meet_steps,
                          ifa.res_period, ifa.res_state, ifa.res_timeout}), 64'd0);
    void'(qa.pop_front());
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_no_result", 64'(ifa.res_valid), 64'd0);
    go_a(2, 8'h03);
    wait_valid_a("after_rst"); cmp_a("after_rst");
    @(negedge clk);
    go_a(1, 8'h3C);
    wait_valid_a("toggle2"); cmp_a("toggle2");
    @(negedge clk);
    chk("excl", 64'(excl_viol), 64'd0);
    chk("queue_empty", 64'(qa.size() + qb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
